// File: rtl/div_seq.sv
// ============================================================================
//  Module   : div_seq
//  Purpose  : Multi-cycle radix-2 restoring divider for the EX stage.
//             Handles DIV (signed) and DIVU (unsigned) and produces one
//             quotient bit per clock. The result is returned as
//             {remainder (HI), quotient (LO)}.
//  Ports    : clk        rising-edge clock
//             rst        asynchronous, active-low reset
//             start_i    divide request, held high until ready_o is seen
//             annul_i    abort/flush; takes priority over start_i
//             signed_i   1 = DIV, 0 = DIVU
//             opdata1_i  dividend
//             opdata2_i  divisor
//             result_o   {remainder, quotient}, valid while ready_o is high
//             ready_o    result valid
//             busy_o     operation in progress
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_seq #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            annul_i,
  input  logic            signed_i,
  input  logic [DW-1:0]   opdata1_i,
  input  logic [DW-1:0]   opdata2_i,
  output logic [2*DW-1:0] result_o,
  output logic            ready_o,
  output logic            busy_o
);

  localparam int CW = $clog2(DW) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2*DW-1:0] sreg;      // upper half: partial remainder, lower half: dividend in / quotient out
  logic [DW-1:0]   divisor;   // latched divisor magnitude
  logic            neg_quot;
  logic            neg_rem;

  // Operand magnitudes. The most negative value negates to itself, which
  // read as unsigned is exactly its magnitude.
  logic [DW-1:0] abs_op1;
  logic [DW-1:0] abs_op2;

  assign abs_op1 = (signed_i && opdata1_i[DW-1]) ? -opdata1_i : opdata1_i;
  assign abs_op2 = (signed_i && opdata2_i[DW-1]) ? -opdata2_i : opdata2_i;

  // One restoring step: the next dividend bit is shifted into the partial
  // remainder before the trial subtraction. The trial value can reach
  // DW+1 bits, so the subtraction is carried out at DW+2 bits and its top
  // bit serves as the borrow.
  logic [DW:0]   trial;
  logic [DW+1:0] diff;
  logic          borrow;

  assign trial  = {sreg[2*DW-1:DW], sreg[DW-1]};
  assign diff   = {1'b0, trial} - {2'b00, divisor};
  assign borrow = diff[DW+1];

  // Final sign correction
  logic [DW-1:0] quot_fix;
  logic [DW-1:0] rem_fix;

  assign quot_fix = neg_quot ? -sreg[DW-1:0]    : sreg[DW-1:0];
  assign rem_fix  = neg_rem  ? -sreg[2*DW-1:DW] : sreg[2*DW-1:DW];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sreg     <= '0;
      divisor  <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !annul_i) begin
            busy_o <= 1'b1;
            if (opdata2_i == '0) begin
              state <= BYZERO;
            end else begin
              sreg     <= {{DW{1'b0}}, abs_op1};
              divisor  <= abs_op2;
              neg_quot <= signed_i & (opdata1_i[DW-1] ^ opdata2_i[DW-1]);
              neg_rem  <= signed_i & opdata1_i[DW-1];
              cnt      <= '0;
              state    <= ON;
            end
          end
        end

        BYZERO: begin
          if (annul_i) begin
            state    <= IDLE;
            result_o <= '0;
            ready_o  <= 1'b0;
            busy_o   <= 1'b0;
          end else begin
            state    <= END;
            result_o <= '0;
            ready_o  <= 1'b1;
            busy_o   <= 1'b0;
          end
        end

        ON: begin
          if (annul_i) begin
            state    <= IDLE;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
            busy_o   <= 1'b0;
          end else if (cnt != CW'(DW)) begin
            if (borrow) begin
              sreg <= {sreg[2*DW-2:0], 1'b0};
            end else begin
              // Remainder always fits in DW bits once the subtraction succeeds.
              sreg <= {DW'(diff), sreg[DW-2:0], 1'b1};
            end
            cnt <= cnt + 1'b1;
          end else begin
            state    <= END;
            result_o <= {rem_fix, quot_fix};
            ready_o  <= 1'b1;
            busy_o   <= 1'b0;
          end
        end

        END: begin
          if (annul_i) begin
            state    <= IDLE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end else if (!start_i) begin
            state   <= IDLE;
            ready_o <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          ready_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// ============================================================================
//  Module   : tb_div_seq
//  Purpose  : Self-checking bench for div_seq. Directed corner cases plus
//             randomized operands, compared against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_seq;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0;
  logic          annul_i = 1'b0;
  logic          signed_i = 1'b0;
  logic [31:0]   opdata1_i = '0;
  logic [31:0]   opdata2_i = '0;
  logic [63:0]   result_o;
  logic          ready_o;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  div_seq #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .annul_i   (annul_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic. Division truncates toward zero and
  // the remainder follows the dividend sign; zero divisor yields zero.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide with start held, measure latency and busy cycles,
  // check the result, that it holds while start stays high, and that
  // dropping start returns to idle.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input bit toggle, input string tag);
    logic [63:0] exp;
    int cyc;
    int busy_cnt;
    int exp_lat;
    exp      = model(sgn, a, b);
    exp_lat  = (b == 32'd0) ? 1 : DW + 1;
    start_i  = 1'b1;
    signed_i = sgn;
    opdata1_i = a;
    opdata2_i = b;
    step();                    // edge E0 has accepted the request
    cyc = 0;
    busy_cnt = 0;
    while (!ready_o && cyc < 100) begin
      if (busy_o) busy_cnt++;
      if (toggle) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = ~signed_i;
      end
      step();
      cyc++;
    end
    check({tag, "_lat"},  64'(cyc),      64'(exp_lat));
    check({tag, "_busy"}, 64'(busy_cnt), 64'(exp_lat));
    check({tag, "_res"},  result_o,      exp);
    step();
    check({tag, "_hold"}, {result_o[62:0], ready_o}, {exp[62:0], 1'b1});
    start_i = 1'b0;
    step();
    check({tag, "_drop"}, {62'd0, ready_o, busy_o}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rs;

    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", {result_o[61:0], ready_o, busy_o}, 64'd0);
    check("reset_res", result_o, 64'd0);
    rst = 1'b1;
    step();

    // start with annul in IDLE is ignored
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd10; opdata2_i = 32'd3;
    step();
    check("idle_annul", {62'd0, ready_o, busy_o}, 64'd0);
    start_i = 1'b0; annul_i = 1'b0;
    step();

    // Directed cases
    run_div(1'b0, 32'd100,       32'd7,        1'b0, "divu_100_7");
    run_div(1'b1, 32'hFFFFFFF9,  32'd2,        1'b0, "div_m7_2");
    run_div(1'b1, 32'd7,         32'hFFFFFFFE, 1'b0, "div_7_m2");
    run_div(1'b1, 32'd5,         32'd0,        1'b0, "div_by0");
    run_div(1'b0, 32'd5,         32'd0,        1'b0, "divu_by0");
    run_div(1'b1, 32'h80000000,  32'hFFFFFFFF, 1'b0, "div_ovf");
    run_div(1'b0, 32'hFFFFFFFF,  32'd1,        1'b0, "divu_max_1");
    run_div(1'b0, 32'd3,         32'hFFFFFFFF, 1'b0, "divu_3_max");
    run_div(1'b0, 32'hFFFFFFFF,  32'h80000001, 1'b0, "divu_bigdiv");
    run_div(1'b1, 32'h87654321,  32'h00001234, 1'b1, "div_toggle");

    // Flush at cycle 10 of ON
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd3;
    step();
    for (int i = 0; i < 9; i++) begin
      check("annul_noready", {63'd0, ready_o}, 64'd0);
      step();
    end
    annul_i = 1'b1;
    start_i = 1'b0;
    step();
    check("annul_out", {result_o[61:0], ready_o, busy_o}, 64'd0);
    check("annul_res", result_o, 64'd0);
    annul_i = 1'b0;
    run_div(1'b0, 32'd9, 32'd3, 1'b0, "after_annul");

    // Asynchronous reset mid-operation
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    repeat (5) step();
    #2;
    rst = 1'b0;
    #1;
    check("arst_out", {62'd0, ready_o, busy_o}, 64'd0);
    check("arst_res", result_o, 64'd0);
    start_i = 1'b0;
    step();
    rst = 1'b1;
    repeat (3) step();
    check("arst_idle", {62'd0, ready_o, busy_o}, 64'd0);
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, 1'b0, "after_arst");

    // Randomized operands
    for (int n = 0; n < 24; n++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = $urandom;
        1: rb = $urandom_range(0, 15);
        2: rb = $urandom | 32'h80000000;
        3: rb = 32'hFFFFFFFF - $urandom_range(0, 3);
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      if (n % 6 == 5) ra = 32'h80000000;
      run_div(rs, ra, rb, 1'b0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
